// File: rtl/dnn_mlp_engine_if.sv
// Host control, status, result and shared-memory read port of the MLP engine.
// master = engine side, slave = host/memory side.
interface dnn_mlp_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int N_OUT      = 10,
  parameter int CLS_W      = $clog2(N_OUT)
);
  logic                   start;
  logic                   reset;
  logic                   busy;
  logic                   done;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic signed [7:0]      mem_data;
  logic [N_OUT-1:0][7:0]  out;
  logic [CLS_W-1:0]       class_idx;
  logic                   class_valid;

  modport master (
    input  start, reset, mem_data,
    output busy, done, mem_addr, out, class_idx, class_valid
  );

  modport slave (
    output start, reset, mem_data,
    input  busy, done, mem_addr, out, class_idx, class_valid
  );
endinterface

// File: rtl/dnn_mlp_engine.sv
// Two-layer MLP over one 1-cycle sync read port; done at start+1+N_HID*(2*N_IN+4)+N_OUT*(N_HID+4) (+N_OUT with DNN_MLP_ARGMAX_EN).
// No backpressure: memory answers every read next cycle; start is ignored while busy.
module dnn_mlp_engine #(
  parameter int                    ADDR_WIDTH       = 16,
  parameter int                    ACC_WIDTH        = 24,
  parameter int                    N_IN             = 400,
  parameter int                    N_HID            = 25,
  parameter int                    N_OUT            = 10,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A      = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W      = 16'h0191,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT_L1 = 16'h29be,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_LUT_L2 = 16'h2abe,
  parameter logic signed [7:0]     BIAS_ONE         = 8'sd1,
  parameter int                    LUT_SHIFT        = 0
) (
  input logic              clk,
  input logic              rst,
  dnn_mlp_engine_if.master mlp
);
  localparam int CLS_W  = $clog2(N_OUT);
  localparam int CNT_W  = $clog2(2 * N_IN + N_HID + N_OUT + 8);
  localparam int NIDX_W = $clog2(N_HID + N_OUT + 1);
  localparam int HID_W  = (N_HID > 1) ? $clog2(N_HID) : 1;

  localparam logic [CNT_W-1:0]  L1_LAST  = CNT_W'(2 * N_IN + 1);
  localparam logic [CNT_W-1:0]  L2_LAST  = CNT_W'(N_HID + 1);
  localparam logic [NIDX_W-1:0] HID_LAST = NIDX_W'(N_HID - 1);
  localparam logic [NIDX_W-1:0] OUT_LAST = NIDX_W'(N_OUT - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = -ACC_WIDTH'(128);

  typedef enum logic [2:0] {
    S_IDLE, S_L1_MAC, S_L1_LUT, S_L2_MAC, S_L2_LUT,
`ifdef DNN_MLP_ARGMAX_EN
    S_ARGMAX,
`endif
    S_DONE
  } state_t;

  state_t                       state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [NIDX_W-1:0]            nidx_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sh;
  logic signed [7:0]            a_q;
  logic signed [7:0]            hid_q [N_HID];
  logic [N_OUT-1:0][7:0]        out_q;
  logic signed [7:0]            mul_a, mul_b;
  logic signed [15:0]           prod;
  logic                         acc_en, acc_first;
  logic [HID_W-1:0]             h_idx;
  logic [7:0]                   lut_idx;
  logic [ADDR_WIDTH-1:0]        base_l1, base_l2, addr;

  // cnt 1 carries the bias word; later cycles carry MAC operands issued one cycle earlier
  always_comb begin
    h_idx     = HID_W'(cnt_q - CNT_W'(2));
    acc_first = (cnt_q == CNT_W'(1));
    acc_en    = ((state_q == S_L1_MAC) && cnt_q[0]) ||
                ((state_q == S_L2_MAC) && (cnt_q != '0));
    if (acc_first) begin
      mul_a = mlp.mem_data;
      mul_b = BIAS_ONE;
    end else begin
      mul_a = (state_q == S_L1_MAC) ? a_q : hid_q[h_idx];
      mul_b = mlp.mem_data;
    end
    prod  = mul_a * mul_b;
    acc_d = acc_first ? ACC_WIDTH'(prod) : acc_q + ACC_WIDTH'(prod);
  end

  always_comb begin
    acc_sh = acc_q >>> LUT_SHIFT;
    if (acc_sh > SAT_HI)      lut_idx = 8'hff;
    else if (acc_sh < SAT_LO) lut_idx = 8'h00;
    else                      lut_idx = acc_sh[7:0] ^ 8'h80;
  end

  always_comb begin
    base_l1 = ADDR_BASE_W + ADDR_WIDTH'(nidx_q) * ADDR_WIDTH'(N_IN + 1);
    base_l2 = ADDR_BASE_W + ADDR_WIDTH'(N_HID * (N_IN + 1))
            + ADDR_WIDTH'(nidx_q) * ADDR_WIDTH'(N_HID + 1);
    addr    = '0;
    case (state_q)
      // even cnt: bias/weight word, odd cnt: input activation
      S_L1_MAC: if (cnt_q != L1_LAST)
                  addr = cnt_q[0] ? ADDR_BASE_A + ADDR_WIDTH'(cnt_q >> 1)
                                  : base_l1 + ADDR_WIDTH'(cnt_q >> 1);
      S_L1_LUT: if (cnt_q == '0) addr = ADDR_BASE_LUT_L1 + ADDR_WIDTH'(lut_idx);
      S_L2_MAC: if (cnt_q != L2_LAST) addr = base_l2 + ADDR_WIDTH'(cnt_q);
      S_L2_LUT: if (cnt_q == '0) addr = ADDR_BASE_LUT_L2 + ADDR_WIDTH'(lut_idx);
      default:  addr = '0;
    endcase
  end

`ifdef DNN_MLP_ARGMAX_EN
  logic [CLS_W-1:0]  class_idx_q, best_idx_q, arg_idx, cand_idx;
  logic signed [7:0] best_val_q, arg_val, cand_val;
  logic              class_valid_q;
  localparam logic [CNT_W-1:0] ARG_LAST = CNT_W'(N_OUT - 1);

  always_comb begin
    arg_idx  = CLS_W'(cnt_q);
    arg_val  = $signed(out_q[arg_idx]);
    cand_idx = best_idx_q;
    cand_val = best_val_q;
    if ((cnt_q == '0) || (arg_val > best_val_q)) begin
      cand_idx = arg_idx;
      cand_val = arg_val;
    end
  end

  assign mlp.class_idx   = class_idx_q;
  assign mlp.class_valid = class_valid_q;
`else
  assign mlp.class_idx   = '0;
  assign mlp.class_valid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || mlp.reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nidx_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      out_q   <= '0;
      for (int h = 0; h < N_HID; h++) hid_q[h] <= '0;
`ifdef DNN_MLP_ARGMAX_EN
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
      best_idx_q    <= '0;
      best_val_q    <= '0;
`endif
    end else begin
      if (acc_en) acc_q <= acc_d;
      case (state_q)
        S_IDLE: if (mlp.start) begin
          state_q <= S_L1_MAC;
          cnt_q   <= '0;
          nidx_q  <= '0;
          out_q   <= '0;
`ifdef DNN_MLP_ARGMAX_EN
          class_idx_q   <= '0;
          class_valid_q <= 1'b0;
`endif
        end
        S_L1_MAC: begin
          if (!cnt_q[0] && (cnt_q != '0)) a_q <= mlp.mem_data;
          if (cnt_q == L1_LAST) begin
            state_q <= S_L1_LUT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_L1_LUT: begin
          if (cnt_q == '0) begin
            cnt_q <= CNT_W'(1);
          end else begin
            hid_q[HID_W'(nidx_q)] <= mlp.mem_data;
            cnt_q <= '0;
            if (nidx_q == HID_LAST) begin
              state_q <= S_L2_MAC;
              nidx_q  <= '0;
            end else begin
              state_q <= S_L1_MAC;
              nidx_q  <= nidx_q + NIDX_W'(1);
            end
          end
        end
        S_L2_MAC: begin
          if (cnt_q == L2_LAST) begin
            state_q <= S_L2_LUT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_L2_LUT: begin
          if (cnt_q == '0) begin
            cnt_q <= CNT_W'(1);
          end else begin
            out_q[CLS_W'(nidx_q)] <= mlp.mem_data;
            cnt_q <= '0;
            if (nidx_q == OUT_LAST) begin
              nidx_q <= '0;
`ifdef DNN_MLP_ARGMAX_EN
              state_q <= S_ARGMAX;
`else
              state_q <= S_DONE;
`endif
            end else begin
              state_q <= S_L2_MAC;
              nidx_q  <= nidx_q + NIDX_W'(1);
            end
          end
        end
`ifdef DNN_MLP_ARGMAX_EN
        S_ARGMAX: begin
          best_idx_q <= cand_idx;
          best_val_q <= cand_val;
          if (cnt_q == ARG_LAST) begin
            class_idx_q   <= cand_idx;
            class_valid_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mlp.mem_addr = addr;
  assign mlp.busy     = (state_q != S_IDLE);
  assign mlp.done     = (state_q == S_DONE);
  assign mlp.out      = out_q;
endmodule

// File: tb/tb_dnn_mlp_engine.sv
// Bench for dnn_mlp_engine (N_IN=4, N_HID=3, N_OUT=4) with a 1-cycle memory and a plain-arithmetic reference model.
// Follows DNN_MLP_ARGMAX_EN when the macro is defined for the build.
module tb_dnn_mlp_engine;
  localparam int NI = 4, NH = 3, NO = 4, AW = 16, ACCW = 24, LSH = 0;
  localparam int BA = 'h0000, BW = 'h0191, BL1 = 'h29be, BL2 = 'h2abe;
  localparam int BW2 = BW + NH * (NI + 1);
`ifdef DNN_MLP_ARGMAX_EN
  localparam bit ARG = 1'b1;
`else
  localparam bit ARG = 1'b0;
`endif
  localparam int T_EXP = 1 + NH * (2 * NI + 4) + NO * (NH + 4) + (ARG ? NO : 0);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  dnn_mlp_engine_if #(.ADDR_WIDTH(AW), .N_OUT(NO)) mif ();
  always @(posedge clk) mif.mem_data <= mem[mif.mem_addr];

  dnn_mlp_engine #(
    .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW), .N_IN(NI), .N_HID(NH), .N_OUT(NO),
    .ADDR_BASE_A(16'h0000), .ADDR_BASE_W(16'h0191),
    .ADDR_BASE_LUT_L1(16'h29be), .ADDR_BASE_LUT_L2(16'h2abe),
    .BIAS_ONE(8'sd1), .LUT_SHIFT(LSH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mlp(mif)
  );

  int tests = 0;
  int fails = 0;
  int exp_out [NO];
  int exp_cls;

  function automatic int sb(input logic [7:0] b);
    return int'($signed(b));
  endfunction

  function automatic int lut(input int base, input int acc);
    logic signed [ACCW-1:0] w;
    int s;
    w = ACCW'(acc);
    s = int'(w) >>> LSH;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return sb(mem[base + s + 128]);
  endfunction

  task automatic model();
    int hid [NH];
    int acc;
    for (int j = 0; j < NH; j++) begin
      acc = sb(mem[BW + j * (NI + 1)]);
      for (int i = 0; i < NI; i++) acc += sb(mem[BA + i]) * sb(mem[BW + j * (NI + 1) + 1 + i]);
      hid[j] = lut(BL1, acc);
    end
    for (int k = 0; k < NO; k++) begin
      acc = sb(mem[BW2 + k * (NH + 1)]);
      for (int h = 0; h < NH; h++) acc += hid[h] * sb(mem[BW2 + k * (NH + 1) + 1 + h]);
      exp_out[k] = lut(BL2, acc);
    end
    exp_cls = 0;
    for (int k = 1; k < NO; k++) if (exp_out[k] > exp_out[exp_cls]) exp_cls = k;
  endtask

  task automatic lut_identity();
    for (int x = 0; x < 256; x++) begin
      mem[BL1 + x] = 8'(x - 128);
      mem[BL2 + x] = 8'(x - 128);
    end
  endtask

  task automatic set_l1(input int a, input int w, input int b);
    for (int i = 0; i < NI; i++) mem[BA + i] = 8'(a);
    for (int j = 0; j < NH; j++) begin
      mem[BW + j * (NI + 1)] = 8'(b);
      for (int i = 0; i < NI; i++) mem[BW + j * (NI + 1) + 1 + i] = 8'(w);
    end
  endtask

  task automatic set_l2(input int w0, input int b [NO]);
    for (int k = 0; k < NO; k++) begin
      mem[BW2 + k * (NH + 1)] = 8'(b[k]);
      for (int h = 0; h < NH; h++) mem[BW2 + k * (NH + 1) + 1 + h] = (h == 0) ? 8'(w0) : 8'h00;
    end
  endtask

  // Start pulse accepted at edge t; n counts cycles t+n, sampled at the negedge.
  task automatic run(input bit poke, output int lat, output int ndone, output int busy_bad,
                     output int first_addr);
    @(negedge clk) mif.start = 1'b1;
    @(negedge clk) mif.start = 1'b0;
    lat = -1; ndone = 0; busy_bad = 0; first_addr = -1;
    for (int n = 1; n <= 150; n++) begin
      if (n == 1) first_addr = int'(mif.mem_addr);
      if (mif.done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if ((lat < 0) || (n == lat)) begin
        if (mif.busy !== 1'b1) busy_bad++;
      end else if (mif.busy !== 1'b0) busy_bad++;
      if (poke && ((n == 50) || (n == lat))) mif.start = 1'b1;
      @(negedge clk) mif.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (mif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", mif.busy); end
    tests++; if (mif.done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", mif.done); end
    tests++; if (mif.mem_addr !== 16'h0) begin fails++; $display("FAIL reset_addr got %0h want 0", mif.mem_addr); end
    tests++; if (mif.out !== '0) begin fails++; $display("FAIL reset_out got %0h want 0", mif.out); end
    tests++; if (mif.class_idx !== '0) begin fails++; $display("FAIL reset_cls got %0d want 0", mif.class_idx); end
    tests++; if (mif.class_valid !== 1'b0) begin fails++; $display("FAIL reset_cvld got %0b want 0", mif.class_valid); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bias_timing();
    int lat, nd, bb, fa;
    lut_identity();
    set_l1(17, 0, 5);
    set_l2(0, '{5, 5, 5, 5});
    run(1'b0, lat, nd, bb, fa);
    tests++; if (lat !== T_EXP) begin fails++; $display("FAIL latency got %0d want %0d", lat, T_EXP); end
    tests++; if (nd !== 1) begin fails++; $display("FAIL done_pulses got %0d want 1", nd); end
    tests++; if (bb !== 0) begin fails++; $display("FAIL busy_window bad_cycles %0d want 0", bb); end
    tests++; if (fa !== BW) begin fails++; $display("FAIL first_addr got %0h want %0h", fa, BW); end
    for (int k = 0; k < NO; k++) begin
      tests++;
      if (int'($signed(mif.out[k])) !== 5) begin
        fails++; $display("FAIL bias_out[%0d] got %0d want 5", k, $signed(mif.out[k]));
      end
    end
    tests++; if (mif.class_idx !== '0) begin fails++; $display("FAIL bias_cls got %0d want 0", mif.class_idx); end
    tests++; if (mif.class_valid !== ARG) begin fails++; $display("FAIL bias_cvld got %0b want %0b", mif.class_valid, ARG); end
  endtask

  task automatic test_saturate();
    int lat, nd, bb, fa;
    int want [NO] = '{127, 127, 124, 127};
    lut_identity();
    set_l1(100, 100, 0);
    set_l2(1, '{0, 2, -3, 3});
    run(1'b0, lat, nd, bb, fa);
    for (int k = 0; k < NO; k++) begin
      tests++;
      if (int'($signed(mif.out[k])) !== want[k]) begin
        fails++; $display("FAIL sat_out[%0d] got %0d want %0d", k, $signed(mif.out[k]), want[k]);
      end
    end
    tests++; if (mif.class_idx !== '0) begin fails++; $display("FAIL sat_cls got %0d want 0", mif.class_idx); end
  endtask

  task automatic test_ties();
    int lat, nd, bb, fa;
    int want [NO] = '{-10, 20, 7, 20};
    set_l2(0, want);
    run(1'b0, lat, nd, bb, fa);
    for (int k = 0; k < NO; k++) begin
      tests++;
      if (int'($signed(mif.out[k])) !== want[k]) begin
        fails++; $display("FAIL tie_out[%0d] got %0d want %0d", k, $signed(mif.out[k]), want[k]);
      end
    end
    tests++;
    if (int'(mif.class_idx) !== (ARG ? 1 : 0)) begin
      fails++; $display("FAIL tie_cls got %0d want %0d", mif.class_idx, ARG ? 1 : 0);
    end
  endtask

  task automatic test_random();
    int lat, nd, bb, fa;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI; i++) mem[BA + i] = 8'($urandom);
      for (int a = 0; a < NH * (NI + 1) + NO * (NH + 1); a++) mem[BW + a] = 8'($urandom);
      for (int x = 0; x < 256; x++) begin
        mem[BL1 + x] = 8'($urandom);
        mem[BL2 + x] = 8'($urandom);
      end
      model();
      run(1'b0, lat, nd, bb, fa);
      tests++; if (lat !== T_EXP) begin fails++; $display("FAIL rnd%0d_latency got %0d want %0d", r, lat, T_EXP); end
      for (int k = 0; k < NO; k++) begin
        tests++;
        if (int'($signed(mif.out[k])) !== exp_out[k]) begin
          fails++; $display("FAIL rnd%0d_out[%0d] got %0d want %0d", r, k, $signed(mif.out[k]), exp_out[k]);
        end
      end
      tests++;
      if (int'(mif.class_idx) !== (ARG ? exp_cls : 0)) begin
        fails++; $display("FAIL rnd%0d_cls got %0d want %0d", r, mif.class_idx, ARG ? exp_cls : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, nd, bb, fa;
    lut_identity();
    set_l1(3, 2, 9);
    set_l2(1, '{4, -6, 1, 0});
    model();
    @(negedge clk) mif.start = 1'b1;
    @(negedge clk) mif.start = 1'b0;
    repeat (10) @(negedge clk);
    mif.reset = 1'b1;
    @(negedge clk);
    tests++; if (mif.busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %0b want 0", mif.busy); end
    tests++; if (mif.mem_addr !== 16'h0) begin fails++; $display("FAIL mid_addr got %0h want 0", mif.mem_addr); end
    tests++; if (mif.out !== '0) begin fails++; $display("FAIL mid_out got %0h want 0", mif.out); end
    tests++; if (mif.class_valid !== 1'b0) begin fails++; $display("FAIL mid_cvld got %0b want 0", mif.class_valid); end
    mif.start = 1'b1;
    @(negedge clk);
    tests++; if (mif.busy !== 1'b0) begin fails++; $display("FAIL reset_vs_start busy got %0b want 0", mif.busy); end
    mif.start = 1'b0;
    mif.reset = 1'b0;
    run(1'b0, lat, nd, bb, fa);
    tests++; if (lat !== T_EXP) begin fails++; $display("FAIL mid_rerun_latency got %0d want %0d", lat, T_EXP); end
    for (int k = 0; k < NO; k++) begin
      tests++;
      if (int'($signed(mif.out[k])) !== exp_out[k]) begin
        fails++; $display("FAIL mid_rerun_out[%0d] got %0d want %0d", k, $signed(mif.out[k]), exp_out[k]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat, nd, bb, fa;
    set_l2(-2, '{1, 30, -40, 30});
    model();
    run(1'b1, lat, nd, bb, fa);
    tests++; if (nd !== 1) begin fails++; $display("FAIL busy_start_pulses got %0d want 1", nd); end
    tests++; if (lat !== T_EXP) begin fails++; $display("FAIL busy_start_latency got %0d want %0d", lat, T_EXP); end
    tests++; if (bb !== 0) begin fails++; $display("FAIL busy_start_window bad_cycles %0d want 0", bb); end
    for (int k = 0; k < NO; k++) begin
      tests++;
      if (int'($signed(mif.out[k])) !== exp_out[k]) begin
        fails++; $display("FAIL busy_start_out[%0d] got %0d want %0d", k, $signed(mif.out[k]), exp_out[k]);
      end
    end
    tests++;
    if (int'(mif.class_idx) !== (ARG ? exp_cls : 0)) begin
      fails++; $display("FAIL busy_start_cls got %0d want %0d", mif.class_idx, ARG ? exp_cls : 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mif.start = 1'b0;
    mif.reset = 1'b0;
    test_reset();
    test_bias_timing();
    test_saturate();
    test_ties();
    test_random();
    test_reset_mid();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
